pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
- Final output stage of the synth datapath. Consumes unsigned PCM samples from the voice/mixer stage over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample into a single-bit pulse-width-modulated Output_Sound for the board's audio pin.
- Each sample is held for a fixed number of PWM frames, so the PWM frame rate sets the sample rate. On FIFO underflow it emits a midscale (silent) level instead of stale data.

Parameters:
- SAMPLE_W, 8, sample width in bits; one PWM frame is 2^SAMPLE_W clocks.
- REPEAT, 1, number of PWM frames each sample is held (range 1..15).
- FIFO_DEPTH, 4, sample FIFO entries (power of two, at least 2).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = play, 0 = stop at the next frame boundary.
- sample_in  in  SAMPLE_W  unsigned sample; 0 = minimum, 2^SAMPLE_W-1 = maximum.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample; equals not-full.
- Output_Sound  out  1  registered PWM output.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: Output_Sound=0, underflow=0, sample_ready=1, fifo_level=0.
  - Internal: FIFO emptied, frame counter cnt=0, repeat counter rep=0, duty=2^(SAMPLE_W-1), state=IDLE.
  - Reset deassertion mid-frame restarts cleanly from IDLE.
- Push: a sample is written on any edge with sample_valid=1 and sample_ready=1, independent of state.
  - Sources may hold sample_valid high across cycles; each accepted edge is one sample.
- FIFO depth and flags:
  - Pop and push on the same edge leave fifo_level unchanged.
  - A push into an empty FIFO is not visible to a pop on the same edge.
  - When full, sample_ready=0. It rises the cycle after a pop.
- State IDLE:
  - cnt held at 0, Output_Sound=0, no pops.
  - When enable=1, go to RUN. That edge is a frame start (load rule below) and cnt stays 0.
- State RUN:
  - cnt increments by 1 each clock and wraps from 2^SAMPLE_W-1 to 0.
  - The wrap edge is a frame start.
- Frame-start load rule:
  - If rep=0 and the FIFO is non-empty: pop into duty, set rep=REPEAT-1.
  - If rep=0 and the FIFO is empty: duty=2^(SAMPLE_W-1), rep=0, pulse underflow on the following cycle.
  - If rep>0: duty is kept and rep decrements.
- Stopping:
  - In RUN with enable=0 at a frame start: go to IDLE, no pop, no underflow, duty kept.
  - enable=0 mid-frame: the current frame completes.
- PWM output:
  - Output_Sound(t+1) = (cnt(t) < duty(t)) while in RUN, otherwise 0. This is a one-clock latency from frame start.
  - duty=0 gives a constant 0.
  - duty=2^SAMPLE_W-1 gives high for 2^SAMPLE_W-1 of every 2^SAMPLE_W clocks.
- Comparison is unsigned and SAMPLE_W bits wide. No arithmetic overflow is possible.
- In steady RUN, one sample is consumed every REPEAT*2^SAMPLE_W clocks.

Test Plan:
- Reset and first frame: hold reset=0 for 4 clocks, push 0x40, release reset, enable=1 → Output_Sound high for exactly 64 clocks starting 1 clock after enable is sampled, low for 192; fifo_level 1→0 at the first frame start.
- Stream: push 0x00, 0xFF, 0x80 back-to-back → frames show 0, then 255, then 128 high clocks; no underflow; sample_ready stays 1.
- Full/backpressure: with enable=0, hold sample_valid=1 for 6 cycles → only 4 accepted, sample_ready=0 after the 4th, fifo_level=4. Then set enable=1 → sample_ready returns to 1 the cycle after the first pop.
- Underflow: run with an empty FIFO → underflow pulses for 1 cycle at every frame start and Output_Sound shows 128 high clocks per frame. Push 0x10 mid-frame → next frame shows 16 high clocks, no underflow.
- REPEAT=3: push 0x20, 0x60 → three consecutive frames of 32 high clocks, then three of 96; pops occur 768 clocks apart.
- Stop/async reset: drop enable at cnt=100 → frame completes, then Output_Sound=0 and cnt=0 in IDLE with the FIFO untouched. Assert reset mid-frame → all outputs at reset values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/pwm_audio_out.sv
// pwm_audio_out: final audio output stage.
// Buffers unsigned PCM samples in a small FIFO and turns each one into a
// single-bit PWM waveform. One PWM frame lasts 2^SAMPLE_W clocks and every
// sample is held for REPEAT frames. An empty FIFO at a frame start produces
// a midscale (silent) frame and a one-cycle underflow pulse.
module pwm_audio_out #(
  parameter int SAMPLE_W   = 8,
  parameter int REPEAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          Output_Sound,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [SAMPLE_W-1:0] MID_LEVEL  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] CNT_MAX    = {SAMPLE_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] CNT_ZERO   = {SAMPLE_W{1'b0}};
  localparam logic [SAMPLE_W-1:0] CNT_ONE    = {{(SAMPLE_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]          REP_RELOAD = 4'(REPEAT - 1);
  localparam logic [LW-1:0]       FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]       LVL_ONE    = LW'(1);
  localparam logic [AW-1:0]       PTR_ONE    = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SAMPLE_W-1:0]   cnt_q, cnt_d;
  logic [3:0]            rep_q, rep_d;
  logic [SAMPLE_W-1:0]   duty_q, duty_d;
  logic                  out_q, out_d;
  logic                  uf_q, uf_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [SAMPLE_W-1:0]   mem_q [FIFO_DEPTH];

  logic fifo_empty_s;
  logic fifo_full_s;
  logic push_s;
  logic pop_s;
  logic frame_start_s;
  logic load_s;

  // Handshake and frame-boundary decode; a stop request at a frame start
  // suppresses the load so the FIFO and duty are left untouched.
  always_comb begin
    fifo_empty_s  = (level_q == {LW{1'b0}});
    fifo_full_s   = (level_q == FULL_LEVEL);
    push_s        = sample_valid && !fifo_full_s;
    frame_start_s = ((state_q == ST_IDLE) && enable) ||
                    ((state_q == ST_RUN) && (cnt_q == CNT_MAX));
    load_s        = frame_start_s && enable;
    pop_s         = load_s && (rep_q == 4'd0) && !fifo_empty_s;
  end

  // Play/stop sequencing and the free-running frame counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (frame_start_s && !enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Frame-start duty/repeat update and the PWM compare for the next cycle.
  always_comb begin
    duty_d = duty_q;
    rep_d  = rep_q;
    uf_d   = 1'b0;
    if (load_s) begin
      if (rep_q == 4'd0) begin
        if (!fifo_empty_s) begin
          duty_d = mem_q[rd_ptr_q];
          rep_d  = REP_RELOAD;
        end else begin
          duty_d = MID_LEVEL;
          rep_d  = 4'd0;
          uf_d   = 1'b1;
        end
      end else begin
        rep_d = rep_q - 4'd1;
      end
    end else begin
      duty_d = duty_q;
    end
    out_d = (state_q == ST_RUN) && (cnt_q < duty_q);
  end

  // FIFO pointer and occupancy bookkeeping; simultaneous push and pop cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      rep_q    <= 4'd0;
      duty_q   <= MID_LEVEL;
      out_q    <= 1'b0;
      uf_q     <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      duty_q   <= duty_d;
      out_q    <= out_d;
      uf_q     <= uf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; cleared on reset so no stale audio survives it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {SAMPLE_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign sample_ready = !fifo_full_s;
  assign Output_Sound = out_q;
  assign underflow    = uf_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: a REPEAT=1 instance and a REPEAT=3 instance share
// clock and reset. Expected behaviour comes from a per-instance sample queue:
// each frame plays the next queued sample (or 128 with an underflow when the
// queue is empty) and the bench counts high clocks per frame.
module tb_pwm_audio_out;

  logic       clock;
  logic       reset;
  logic       en1, vld1, rdy1, snd1, uf1;
  logic [7:0] din1;
  logic [2:0] lvl1;
  logic       en3, vld3, rdy3, snd3, uf3;
  logic [7:0] din3;
  logic [2:0] lvl3;

  int n_checks;
  int n_pass;
  int q1[$];
  int q3[$];

  pwm_audio_out #(.SAMPLE_W(8), .REPEAT(1), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(en1), .sample_in(din1),
    .sample_valid(vld1), .sample_ready(rdy1), .Output_Sound(snd1),
    .underflow(uf1), .fifo_level(lvl1)
  );

  pwm_audio_out #(.SAMPLE_W(8), .REPEAT(3), .FIFO_DEPTH(4)) dut3 (
    .clock(clock), .reset(reset), .enable(en3), .sample_in(din3),
    .sample_valid(vld3), .sample_ready(rdy3), .Output_Sound(snd3),
    .underflow(uf3), .fifo_level(lvl3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Push one sample at a negedge; the model keeps it only if there was room.
  task automatic push(input bit sel, input logic [7:0] v);
    if (sel) begin vld3 = 1'b1; din3 = v; end
    else begin vld1 = 1'b1; din1 = v; end
    @(negedge clock);
    if (sel) begin if (q3.size() < 4) q3.push_back(int'(v)); vld3 = 1'b0; end
    else begin if (q1.size() < 4) q1.push_back(int'(v)); vld1 = 1'b0; end
  endtask

  // Enable playback; returns at the negedge right after the first frame start.
  task automatic start_run(input bit sel);
    if (sel) en3 = 1'b1; else en1 = 1'b1;
    @(negedge clock);
  endtask

  // Observe one whole frame starting just after a frame-start edge.
  task automatic run_frame(input bit sel, input int push_at, input logic [7:0] pv,
                           input int stop_at, output int highs, output int ufs);
    highs = 0;
    ufs   = 0;
    for (int k = 0; k < 256; k++) begin
      ufs += sel ? int'(uf3) : int'(uf1);
      if (k == push_at) begin
        if (sel) begin vld3 = 1'b1; din3 = pv; end
        else begin vld1 = 1'b1; din1 = pv; end
      end
      if (k == stop_at) begin
        if (sel) en3 = 1'b0; else en1 = 1'b0;
      end
      @(negedge clock);
      if (k == push_at) begin
        if (sel) begin if (q3.size() < 4) q3.push_back(int'(pv)); end
        else begin if (q1.size() < 4) q1.push_back(int'(pv)); end
        vld1 = 1'b0;
        vld3 = 1'b0;
      end
      highs += sel ? int'(snd3) : int'(snd1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en1 = 1'b0; vld1 = 1'b0; din1 = 8'd0;
    en3 = 1'b0; vld3 = 1'b0; din3 = 8'd0;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({snd1, uf1, rdy1, lvl1} !== {1'b0, 1'b0, 1'b1, 3'd0})
      $display("FAIL reset_dut1: got snd=%b uf=%b rdy=%b lvl=%0d, want 0 0 1 0", snd1, uf1, rdy1, lvl1);
    else n_pass++;
    n_checks++;
    if ({snd3, uf3, rdy3, lvl3} !== {1'b0, 1'b0, 1'b1, 3'd0})
      $display("FAIL reset_dut3: got snd=%b uf=%b rdy=%b lvl=%0d, want 0 0 1 0", snd3, uf3, rdy3, lvl3);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    q1.delete();
    q3.delete();
  endtask

  task automatic test_first_frame();
    int h, u;
    test_reset();
    push(1'b0, 8'h40);
    n_checks++;
    if (lvl1 !== 3'd1) $display("FAIL first_level_pre: got %0d want 1", lvl1); else n_pass++;
    start_run(1'b0);
    void'(q1.pop_front());
    n_checks++;
    if (lvl1 !== 3'd0) $display("FAIL first_level_pop: got %0d want 0", lvl1); else n_pass++;
    run_frame(1'b0, -1, 8'h00, -1, h, u);
    n_checks++;
    if (h !== 64 || u !== 0) $display("FAIL first_frame: got highs=%0d uf=%0d want 64 0", h, u); else n_pass++;
  endtask

  task automatic test_stream();
    int h, u, exp_h;
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h80;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy1 !== 1'b1) $display("FAIL stream_ready: got %b want 1", rdy1); else n_pass++;
      push(1'b0, vals[i]);
    end
    start_run(1'b0);
    for (int f = 0; f < 3; f++) begin
      exp_h = (q1.size() > 0) ? q1.pop_front() : 128;
      run_frame(1'b0, -1, 8'h00, -1, h, u);
      n_checks++;
      if (h !== exp_h || u !== 0)
        $display("FAIL stream_frame%0d: got highs=%0d uf=%0d want %0d 0", f, h, u, exp_h);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int h, u, exp_h;
    logic [7:0] v;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      vld1 = 1'b1;
      din1 = v;
      n_checks++;
      if (rdy1 !== (q1.size() < 4))
        $display("FAIL bp_ready%0d: got %b want %b", i, rdy1, (q1.size() < 4));
      else n_pass++;
      @(negedge clock);
      if (q1.size() < 4) q1.push_back(int'(v));
    end
    vld1 = 1'b0;
    n_checks++;
    if (lvl1 !== 3'd4 || rdy1 !== 1'b0)
      $display("FAIL bp_full: got lvl=%0d rdy=%b want 4 0", lvl1, rdy1);
    else n_pass++;
    start_run(1'b0);
    exp_h = q1.pop_front();
    n_checks++;
    if (lvl1 !== 3'd3 || rdy1 !== 1'b1)
      $display("FAIL bp_after_pop: got lvl=%0d rdy=%b want 3 1", lvl1, rdy1);
    else n_pass++;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) exp_h = (q1.size() > 0) ? q1.pop_front() : 128;
      run_frame(1'b0, -1, 8'h00, -1, h, u);
      n_checks++;
      if (h !== exp_h || u !== 0)
        $display("FAIL bp_frame%0d: got highs=%0d uf=%0d want %0d 0", f, h, u, exp_h);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    int h, u;
    int exp_h [4];
    int exp_u [4];
    int pat [4];
    exp_h[0] = 128; exp_h[1] = 128; exp_h[2] = 16; exp_h[3] = 128;
    exp_u[0] = 1;   exp_u[1] = 1;   exp_u[2] = 0;  exp_u[3] = 1;
    pat[0] = -1;    pat[1] = 100;   pat[2] = -1;   pat[3] = -1;
    test_reset();
    start_run(1'b0);
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, pat[f], 8'h10, -1, h, u);
      n_checks++;
      if (h !== exp_h[f] || u !== exp_u[f])
        $display("FAIL underflow_frame%0d: got highs=%0d uf=%0d want %0d %0d", f, h, u, exp_h[f], exp_u[f]);
      else n_pass++;
      if (f == 1) void'(q1.pop_front());
    end
  endtask

  task automatic test_random_stream();
    int h, u, exp_h, pk;
    test_reset();
    for (int i = 0; i < 3; i++) push(1'b0, 8'($urandom));
    start_run(1'b0);
    for (int f = 0; f < 8; f++) begin
      exp_h = (q1.size() > 0) ? q1.pop_front() : 128;
      pk = int'($urandom_range(250, 5));
      run_frame(1'b0, pk, 8'($urandom), -1, h, u);
      n_checks++;
      if (h !== exp_h || u !== 0)
        $display("FAIL random_frame%0d: got highs=%0d uf=%0d want %0d 0", f, h, u, exp_h);
      else n_pass++;
    end
  endtask

  task automatic test_repeat3();
    int h, u;
    int exp_h [7];
    int exp_u [7];
    exp_h[0] = 32; exp_h[1] = 32; exp_h[2] = 32;
    exp_h[3] = 96; exp_h[4] = 96; exp_h[5] = 96; exp_h[6] = 128;
    for (int i = 0; i < 7; i++) exp_u[i] = (i == 6) ? 1 : 0;
    test_reset();
    push(1'b1, 8'h20);
    push(1'b1, 8'h60);
    n_checks++;
    if (lvl3 !== 3'd2) $display("FAIL rep3_level_pre: got %0d want 2", lvl3); else n_pass++;
    start_run(1'b1);
    for (int f = 0; f < 7; f++) begin
      n_checks++;
      if (lvl3 !== ((f < 3) ? 3'd1 : 3'd0))
        $display("FAIL rep3_level%0d: got %0d want %0d", f, lvl3, (f < 3) ? 1 : 0);
      else n_pass++;
      run_frame(1'b1, -1, 8'h00, -1, h, u);
      n_checks++;
      if (h !== exp_h[f] || u !== exp_u[f])
        $display("FAIL rep3_frame%0d: got highs=%0d uf=%0d want %0d %0d", f, h, u, exp_h[f], exp_u[f]);
      else n_pass++;
    end
  endtask

  task automatic test_stop_and_async_reset();
    int h, u;
    test_reset();
    push(1'b0, 8'd200);
    push(1'b0, 8'h30);
    start_run(1'b0);
    void'(q1.pop_front());
    run_frame(1'b0, -1, 8'h00, 100, h, u);
    n_checks++;
    if (h !== 200 || u !== 0) $display("FAIL stop_frame: got highs=%0d uf=%0d want 200 0", h, u); else n_pass++;
    run_frame(1'b0, -1, 8'h00, -1, h, u);
    n_checks++;
    if (h !== 0 || u !== 0 || lvl1 !== 3'd1)
      $display("FAIL stop_idle: got highs=%0d uf=%0d lvl=%0d want 0 0 1", h, u, lvl1);
    else n_pass++;
    push(1'b0, 8'h55);
    start_run(1'b0);
    void'(q1.pop_front());
    repeat (10) @(negedge clock);
    n_checks++;
    if (snd1 !== 1'b1 || lvl1 !== 3'd1)
      $display("FAIL restart_mid: got snd=%b lvl=%0d want 1 1", snd1, lvl1);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({snd1, uf1, rdy1, lvl1} !== {1'b0, 1'b0, 1'b1, 3'd0})
      $display("FAIL async_reset: got snd=%b uf=%b rdy=%b lvl=%0d want 0 0 1 0", snd1, uf1, rdy1, lvl1);
    else n_pass++;
    en1 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_first_frame();
    test_stream();
    test_backpressure();
    test_underflow();
    test_random_stream();
    test_repeat3();
    test_stop_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
